regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates two writeback sources (requester 0: ALU, requester 1: load unit)
// onto the single write port of a register file. It also keeps a per-register
// scoreboard of outstanding writebacks, which is used to stall instruction
// issue on RAW and WAW hazards.
//
// Ports
//   clock             in   rising-edge clock for all state
//   reset             in   synchronous, active-high reset
//   req0/addr0/data0  in   requester 0 write request, destination, data
//   gnt0              out  combinational grant to requester 0
//   req1/addr1/data1  in   requester 1 write request, destination, data
//   gnt1              out  combinational grant to requester 1
//   issue_valid       in   instruction issue attempt
//   issue_dst         in   destination register of the issuing instruction
//   src_a, src_b      in   source registers of the issuing instruction
//   hazard            out  combinational; the issue must stall this cycle
//   rf_write          out  registered write strobe to the register file
//   rf_write_address  out  registered write address
//   rf_write_data     out  registered write data
//   pending           out  scoreboard; bit i set = register i awaits writeback
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 req0,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [DATA_W-1:0]    data0,
  output logic                 gnt0,

  input  logic                 req1,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [DATA_W-1:0]    data1,
  output logic                 gnt1,

  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_dst,
  input  logic [ADDR_W-1:0]    src_a,
  input  logic [ADDR_W-1:0]    src_b,
  output logic                 hazard,

  output logic                 rf_write,
  output logic [ADDR_W-1:0]    rf_write_address,
  output logic [DATA_W-1:0]    rf_write_data,
  output logic [2**ADDR_W-1:0] pending
);

  localparam int NUM_REGS = 2**ADDR_W;

  // Identity of the requester granted most recently.
  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_grant_e;

  last_grant_e         last_grant_q, last_grant_d;
  logic                rf_write_q,   rf_write_d;
  logic [ADDR_W-1:0]   rf_addr_q,    rf_addr_d;
  logic [DATA_W-1:0]   rf_data_q,    rf_data_d;
  logic [NUM_REGS-1:0] pending_q,    pending_d;

  logic gnt0_c, gnt1_c;
  logic hazard_c;
  logic issue_accept;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. On a tie the requester that was not granted most
  // recently wins. Nothing is granted while reset is high, so requests held
  // across reset are simply still waiting afterwards.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (last_grant_q == LAST_REQ1) gnt0_c = 1'b1;
        else                           gnt1_c = 1'b1;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection: a source (RAW) or the destination (WAW) still awaits its
  // writeback. Forced low during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard_c = 1'b0;
    if (!reset && issue_valid) begin
      hazard_c = pending_q[src_a] | pending_q[src_b] | pending_q[issue_dst];
    end
  end

  assign issue_accept = issue_valid && !hazard_c;

  // ---------------------------------------------------------------------------
  // Next-state for the write port and the last-grant pointer. Without a grant
  // the strobe drops and address/data keep their previous values.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_write_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;
    last_grant_d = last_grant_q;
    if (gnt0_c) begin
      rf_write_d   = 1'b1;
      rf_addr_d    = addr0;
      rf_data_d    = data0;
      last_grant_d = LAST_REQ0;
    end else if (gnt1_c) begin
      rf_write_d   = 1'b1;
      rf_addr_d    = addr1;
      rf_data_d    = data1;
      last_grant_d = LAST_REQ1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next-state. The clear tracks the register file commit of the
  // currently registered write; the issue set is applied afterwards so that a
  // set and a clear of the same bit on one edge leaves the bit set.
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    if (rf_write_q) pending_d[rf_addr_q] = 1'b0;
    if (issue_accept) pending_d[issue_dst] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset also cancels a write already registered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    if (reset) begin
      rf_write_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
      pending_q    <= '0;
      last_grant_q <= LAST_REQ1;
    end else begin
      rf_write_q   <= rf_write_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign gnt0             = gnt0_c;
  assign gnt1             = gnt1_c;
  assign hazard           = hazard_c;
  assign rf_write         = rf_write_q;
  assign rf_write_address = rf_addr_q;
  assign rf_write_data    = rf_data_q;
  assign pending          = pending_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter. A behavioural model predicts
// grants, hazard and the scoreboard each cycle; expected register-file writes
// are queued when a grant is predicted and popped when the write strobe is
// due. Directed scenarios add explicit checks of the key behaviours.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 2**AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, gnt0, gnt1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          issue_valid, hazard;
  logic [AW-1:0] issue_dst, src_a, src_b;
  logic          rf_write;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic [NR-1:0] pending;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .req0             (req0),
    .addr0            (addr0),
    .data0            (data0),
    .gnt0             (gnt0),
    .req1             (req1),
    .addr1            (addr1),
    .data1            (data1),
    .gnt1             (gnt1),
    .issue_valid      (issue_valid),
    .issue_dst        (issue_dst),
    .src_a            (src_a),
    .src_b            (src_b),
    .hazard           (hazard),
    .rf_write         (rf_write),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .pending          (pending)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of expected register-file writes.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  // Reference model state.
  logic          m_last;   // 1: requester 1 granted most recently
  logic          m_wr;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [NR-1:0] m_pend;

  task automatic model_reset();
    m_last  = 1'b1;
    m_wr    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_pend  = '0;
    exp_q.delete();
  endtask

  // One clock cycle: check all outputs at the falling edge against the model,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic step();
    logic eg0, eg1, eh;
    logic [NR-1:0] np;
    wr_t w;
    @(negedge clock);
    eg0 = !reset && req0 && (!req1 || m_last);
    eg1 = !reset && req1 && (!req0 || !m_last);
    eh  = !reset && issue_valid &&
          (m_pend[src_a] || m_pend[src_b] || m_pend[issue_dst]);
    check("gnt0", gnt0, eg0);
    check("gnt1", gnt1, eg1);
    check("hazard", hazard, eh);
    check("rf_write", rf_write, m_wr);
    check("pending", pending, m_pend);
    if (m_wr) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got write to %0d with no expected entry", rf_write_address);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", rf_write_address, w.a);
        check("wr_data", rf_write_data, w.d);
      end
    end else begin
      check("hold_addr", rf_write_address, m_waddr);
      check("hold_data", rf_write_data, m_wdata);
    end

    if (reset) begin
      model_reset();
    end else begin
      np = m_pend;
      if (m_wr) np[m_waddr] = 1'b0;
      if (issue_valid && !eh) np[issue_dst] = 1'b1;
      m_pend = np;
      if (eg0) begin
        exp_q.push_back('{a: addr0, d: data0});
        m_wr = 1'b1; m_waddr = addr0; m_wdata = data0; m_last = 1'b0;
      end else if (eg1) begin
        exp_q.push_back('{a: addr1, d: data1});
        m_wr = 1'b1; m_waddr = addr1; m_wdata = data1; m_last = 1'b1;
      end else begin
        m_wr = 1'b0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; addr0 = a0; data0 = d0;
    req1 = r1; addr1 = a1; data1 = d1;
  endtask

  task automatic set_issue(input logic v, input logic [AW-1:0] dst,
                           input logic [AW-1:0] sa, input logic [AW-1:0] sb);
    issue_valid = v; issue_dst = dst; src_a = sa; src_b = sb;
  endtask

  logic prev_g0;

  initial begin
    reset = 1'b1;
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    set_issue(1'b0, '0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    model_reset();

    // Reset state.
    check("rst_rf_write", rf_write, 1'b0);
    check("rst_addr", rf_write_address, 3'd0);
    check("rst_data", rf_write_data, 16'h0000);
    check("rst_pending", pending, 8'h00);

    // Requests and an issue present during reset: nothing granted, no hazard.
    set_req(1'b1, 3'd2, 16'h1111, 1'b1, 3'd5, 16'h2222);
    set_issue(1'b1, 3'd1, 3'd0, 3'd0);
    #1;
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_hazard", hazard, 1'b0);
    step();

    // First tie after reset: requester 0, then requester 1.
    reset = 1'b0;
    set_issue(1'b0, '0, '0, '0);
    #1;
    check("tie1_gnt0", gnt0, 1'b1);
    step();
    check("tie1_wr", rf_write, 1'b1);
    check("tie1_addr", rf_write_address, 3'd2);
    check("tie1_data", rf_write_data, 16'h1111);
    check("tie2_gnt1", gnt1, 1'b1);
    step();
    check("tie2_wr", rf_write, 1'b1);
    check("tie2_addr", rf_write_address, 3'd5);
    check("tie2_data", rf_write_data, 16'h2222);
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("idle_wr", rf_write, 1'b0);
    check("idle_hold_addr", rf_write_address, 3'd5);

    // RAW: dst 3 issued, a reader of r3 stalls until the writeback commits.
    set_issue(1'b1, 3'd3, 3'd0, 3'd0);
    step();
    check("raw_pend_set", pending, 8'h08);
    set_issue(1'b1, 3'd6, 3'd3, 3'd0);
    #1;
    check("raw_hazard", hazard, 1'b1);
    step();
    check("raw_stalled", pending, 8'h08);
    set_issue(1'b0, '0, '0, '0);
    set_req(1'b0, '0, '0, 1'b1, 3'd3, 16'hABCD);
    step();
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("raw_pend_clr", pending, 8'h00);
    set_issue(1'b1, 3'd6, 3'd3, 3'd0);
    #1;
    check("raw_hazard_gone", hazard, 1'b0);
    set_issue(1'b0, '0, '0, '0);

    // Set wins: issue dst 4 on the edge where the write to 4 commits.
    set_req(1'b1, 3'd4, 16'h4444, 1'b0, '0, '0);
    step();
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    set_issue(1'b1, 3'd4, 3'd0, 3'd1);
    #1;
    check("setwin_nohaz", hazard, 1'b0);
    step();
    check("setwin_pend", pending, 8'h10);

    // WAW: destination pending, sources clear.
    set_issue(1'b1, 3'd4, 3'd1, 3'd2);
    #1;
    check("waw_hazard", hazard, 1'b1);
    set_issue(1'b0, 3'd4, 3'd1, 3'd2);
    #1;
    check("waw_novalid", hazard, 1'b0);
    set_req(1'b0, '0, '0, 1'b1, 3'd4, 16'h0404);
    step();
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check("waw_clr", pending, 8'h00);

    // Reset in the cycle after a grant cancels the write and the scoreboard.
    set_issue(1'b1, 3'd7, 3'd0, 3'd0);
    step();
    set_issue(1'b0, '0, '0, '0);
    set_req(1'b1, 3'd1, 16'h0101, 1'b1, 3'd6, 16'h0606);
    step();
    check("pre_rst_wr", rf_write, 1'b1);
    reset = 1'b1;
    #1;
    check("rst2_gnt0", gnt0, 1'b0);
    check("rst2_gnt1", gnt1, 1'b0);
    step();
    check("rst2_wr", rf_write, 1'b0);
    check("rst2_pend", pending, 8'h00);
    reset = 1'b0;
    #1;
    check("rst2_tie_gnt0", gnt0, 1'b1);
    step();

    // Both held: grants must strictly alternate.
    prev_g0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, AW'(i), DW'(16'h1000 + i), 1'b1, AW'(7 - i), DW'(16'h2000 + i));
      #1;
      check("rr_alt", gnt0, !prev_g0);
      prev_g0 = gnt0;
      step();
    end
    set_req(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    step();
    check("sb_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
